// File: rtl/pwm_play_queue_pkg.sv
// rtl/pwm_play_queue_pkg.sv - shared types for the PWM playback descriptor queue
package pwm_queue_pkg;

    localparam int GAP_W   = 16;
    localparam int DESC_AW = 32;

    typedef struct packed {
        logic [DESC_AW-1:0] start;
        logic [DESC_AW-1:0] stop;
    } pwm_desc_t;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        PLAY,
        GAP,
        ABORT
    } pwm_q_state_t;

endpackage

// File: rtl/pwm_play_queue_if.sv
// rtl/pwm_play_queue_if.sv - descriptor push and loader start/stop/done signal bundle
interface pwm_play_queue_if #(
    parameter int AW = 32
);
    logic          push_valid;
    logic          push_rdy;
    logic [AW-1:0] push_startaddr;
    logic [AW-1:0] push_stopaddr;
    logic          play_start;
    logic          play_stop;
    logic [AW-1:0] play_startaddr;
    logic [AW-1:0] play_stopaddr;
    logic          play_done;

    modport master (
        output push_valid, push_startaddr, push_stopaddr, play_done,
        input  push_rdy, play_start, play_stop, play_startaddr, play_stopaddr
    );

    modport slave (
        input  push_valid, push_startaddr, push_stopaddr, play_done,
        output push_rdy, play_start, play_stop, play_startaddr, play_stopaddr
    );
endinterface

// File: rtl/pwm_play_queue_desc_fifo.sv
// rtl/pwm_play_queue_desc_fifo.sv - show-ahead DEPTH-entry descriptor FIFO with clear
module pwm_desc_fifo
    import pwm_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         clear,
    input  pwm_desc_t                    wdata,
    output pwm_desc_t                    head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    pwm_desc_t         mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]     cnt_q;
    logic              do_push, do_pop;

    assign full    = (cnt_q == LW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];
    assign level   = cnt_q;

    // DEPTH is a power of two, so the pointers wrap on their own
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            cnt_q <= cnt_q + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end
endmodule

// File: rtl/pwm_play_queue.sv
// rtl/pwm_play_queue.sv - back-to-back buffer launcher for the PWM loader; PWM_QUEUE_LOOP_EN adds looping
module pwm_play_queue
    import pwm_queue_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int GAP_CYCLES = 0,
    parameter int AW         = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    pwm_play_queue_if.slave             bus,
    input  logic                        flush,
`ifdef PWM_QUEUE_LOOP_EN
    input  logic                        loop,
`endif
    output logic [$clog2(DEPTH+1)-1:0]  level,
    output logic                        busy,
    output logic                        irq_drained,
    output logic                        irq_bad
);
    pwm_q_state_t      state_q, state_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [AW-1:0]     start_q, start_d, stop_q, stop_d;
    logic              play_start_q, play_start_d, play_stop_q, play_stop_d;
    logic              drained_q, drained_d, bad_q, bad_d;
    logic              fifo_full, fifo_empty, fifo_pop, fifo_push;
    pwm_desc_t         fifo_head, fifo_wdata;
    logic              loopback, accept, desc_ok;

`ifdef PWM_QUEUE_LOOP_EN
    assign loopback = loop && bus.play_done && (state_q == PLAY) && !flush;
`else
    assign loopback = 1'b0;
`endif

    assign bus.push_rdy = !fifo_full && !flush && !loopback;
    assign accept       = bus.push_valid && bus.push_rdy;
    assign desc_ok      = bus.push_stopaddr > bus.push_startaddr;
    assign fifo_push    = loopback || (accept && desc_ok);

    // The loopback path re-queues the descriptor that just finished
    always_comb begin
        fifo_wdata = '0;
        if (loopback) begin
            fifo_wdata.start = DESC_AW'(start_q);
            fifo_wdata.stop  = DESC_AW'(stop_q);
        end else begin
            fifo_wdata.start = DESC_AW'(bus.push_startaddr);
            fifo_wdata.stop  = DESC_AW'(bus.push_stopaddr);
        end
    end

    pwm_desc_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .clear (flush),
        .wdata (fifo_wdata),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    always_comb begin
        state_d      = state_q;
        gap_d        = gap_q;
        start_d      = start_q;
        stop_d       = stop_q;
        fifo_pop     = 1'b0;
        play_start_d = 1'b0;
        play_stop_d  = 1'b0;
        drained_d    = 1'b0;
        bad_d        = accept && !desc_ok;
        case (state_q)
            IDLE: begin
                if (!flush && !fifo_empty) begin
                    fifo_pop = 1'b1;
                    start_d  = fifo_head.start[AW-1:0];
                    stop_d   = fifo_head.stop[AW-1:0];
                    state_d  = LAUNCH;
                end
            end
            LAUNCH: begin
                if (flush) begin
                    state_d = ABORT;
                end else begin
                    play_start_d = 1'b1;
                    state_d      = PLAY;
                end
            end
            PLAY: begin
                if (flush) begin
                    state_d = ABORT;
                end else if (bus.play_done) begin
                    gap_d   = GAP_W'(GAP_CYCLES);
                    state_d = GAP;
                end
            end
            GAP: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (gap_q != '0) begin
                    gap_d = gap_q - GAP_W'(1);
                end else if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    start_d  = fifo_head.start[AW-1:0];
                    stop_d   = fifo_head.stop[AW-1:0];
                    state_d  = LAUNCH;
                end else begin
                    drained_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            ABORT: begin
                play_stop_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            gap_q        <= '0;
            start_q      <= '0;
            stop_q       <= '0;
            play_start_q <= 1'b0;
            play_stop_q  <= 1'b0;
            drained_q    <= 1'b0;
            bad_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            gap_q        <= gap_d;
            start_q      <= start_d;
            stop_q       <= stop_d;
            play_start_q <= play_start_d;
            play_stop_q  <= play_stop_d;
            drained_q    <= drained_d;
            bad_q        <= bad_d;
        end
    end

    assign bus.play_start     = play_start_q;
    assign bus.play_stop      = play_stop_q;
    assign bus.play_startaddr = start_q;
    assign bus.play_stopaddr  = stop_q;
    assign busy               = (state_q != IDLE);
    assign irq_drained        = drained_q;
    assign irq_bad            = bad_q;
endmodule

// File: tb/tb_pwm_play_queue.sv
// tb/tb_pwm_play_queue.sv - directed bench with a queue-level reference model for pwm_play_queue
module tb_pwm_play_queue;
    localparam int DEPTH = 8;
    localparam int GAP   = 4;
    localparam int AW    = 32;
`ifdef PWM_QUEUE_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       loop = 1'b0;
    logic [3:0] level;
    logic       busy, irq_drained, irq_bad;

    always #5 clk = ~clk;

    pwm_play_queue_if #(.AW(AW)) bus ();

    pwm_play_queue #(.DEPTH(DEPTH), .GAP_CYCLES(GAP), .AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .flush       (flush),
`ifdef PWM_QUEUE_LOOP_EN
        .loop        (loop),
`endif
        .level       (level),
        .busy        (busy),
        .irq_drained (irq_drained),
        .irq_bad     (irq_bad)
    );

    int vectors = 0;
    int miscompares = 0;
    int drained_seen = 0;
    int starts_seen = 0;
    int stops_seen = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Reference model: a descriptor list plus "what happens at the next edge" flags
    typedef struct packed { logic [31:0] s; logic [31:0] e; } d_t;
    d_t mq[$];
    d_t cur;
    bit m_valid = 1'b0;
    bit m_launch, m_playing, m_abort;
    int m_gap = -1;
    bit e_start, e_stop, e_drained, e_bad;

    function automatic bit model_loopback();
        return LOOP_EN && loop && m_playing && bus.play_done && !flush;
    endfunction

    function automatic bit model_rdy();
        return (mq.size() < DEPTH) && !flush && !model_loopback();
    endfunction

    always @(posedge clk) begin
        bit acc;
        if (rst) begin
            mq.delete();
            cur = '0;
            m_launch = 0; m_playing = 0; m_abort = 0; m_gap = -1;
            e_start = 0; e_stop = 0; e_drained = 0; e_bad = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            acc = bus.push_valid && model_rdy();
            e_start = 0; e_stop = 0; e_drained = 0; e_bad = 0;
            if (flush) mq.delete();
            if (m_abort) begin
                e_stop = 1; m_abort = 0;
            end else if (flush) begin
                if (m_launch || m_playing) m_abort = 1;
                m_launch = 0; m_playing = 0; m_gap = -1;
            end else if (m_launch) begin
                e_start = 1; m_launch = 0; m_playing = 1;
            end else if (m_playing) begin
                if (bus.play_done) begin
                    if (model_loopback() && mq.size() < DEPTH) mq.push_back(cur);
                    m_playing = 0; m_gap = GAP;
                end
            end else if (m_gap > 0) begin
                m_gap--;
            end else if (mq.size() > 0) begin
                cur = mq.pop_front(); m_launch = 1; m_gap = -1;
            end else if (m_gap == 0) begin
                e_drained = 1; m_gap = -1;
            end
            if (acc) begin
                if (bus.push_stopaddr > bus.push_startaddr)
                    mq.push_back('{s: bus.push_startaddr, e: bus.push_stopaddr});
                else
                    e_bad = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("play_start", bus.play_start, e_start);
            chk("play_stop", bus.play_stop, e_stop);
            chk("irq_drained", irq_drained, e_drained);
            chk("irq_bad", irq_bad, e_bad);
            chk("level", level, mq.size());
            chk("busy", busy, m_launch || m_playing || m_abort || (m_gap >= 0));
            chk("push_rdy", bus.push_rdy, model_rdy());
            chk("play_startaddr", bus.play_startaddr, cur.s);
            chk("play_stopaddr", bus.play_stopaddr, cur.e);
        end
        drained_seen += int'(irq_drained);
        starts_seen  += int'(bus.play_start);
        stops_seen   += int'(bus.play_stop);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [31:0] s, input logic [31:0] e);
        bus.push_valid = 1'b1;
        bus.push_startaddr = s;
        bus.push_stopaddr = e;
        step();
        bus.push_valid = 1'b0;
    endtask

    task automatic pulse_done();
        bus.play_done = 1'b1;
        step();
        bus.play_done = 1'b0;
    endtask

    task automatic wait_start(output int n);
        n = 0;
        while (!bus.play_start && n < 60) begin
            step();
            n++;
        end
        if (n >= 60) chk("start_timeout", bus.play_start, 1);
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    initial begin
        int n, snap;
        bus.push_valid = 0; bus.push_startaddr = 0; bus.push_stopaddr = 0; bus.play_done = 0;
        run(2);
        chk("rst_level", level, 0);
        chk("rst_busy", busy, 0);
        chk("rst_startaddr", bus.play_startaddr, 0);
        rst = 0;
        step();

        // single descriptor: start two edges after acceptance
        push(32'h1000, 32'h2000);
        chk("t1_level_after_push", level, 1);
        step();
        chk("t1_no_start_k1", bus.play_start, 0);
        chk("t1_busy", busy, 1);
        step();
        chk("t1_start_k2", bus.play_start, 1);
        chk("t1_startaddr", bus.play_startaddr, 32'h1000);
        chk("t1_stopaddr", bus.play_stopaddr, 32'h2000);
        step();
        chk("t1_start_one_cycle", bus.play_start, 0);
        snap = drained_seen;
        pulse_done();
        run(8);
        chk("t1_drained_once", drained_seen - snap, 1);
        chk("t1_idle", busy, 0);

        // play_done outside PLAY does nothing
        pulse_done();
        run(2);
        chk("idle_done_ignored", busy, 0);

        // three segments with GAP_CYCLES=4
        push(32'h10, 32'h20);
        push(32'h30, 32'h40);
        push(32'h50, 32'h60);
        wait_start(n);
        chk("t2_a_addr", bus.play_startaddr, 32'h10);
        for (int i = 0; i < 3; i++) begin
            run(2);
            snap = drained_seen;
            pulse_done();
            if (i < 2) begin
                wait_start(n);
                chk("t2_gap_edges", n, 6);
                chk("t2_addr", bus.play_startaddr, (i == 0) ? 32'h30 : 32'h50);
            end else begin
                run(10);
                chk("t2_drained_once", drained_seen - snap, 1);
                chk("t2_level", level, 0);
                chk("t2_idle", busy, 0);
            end
        end

        // fill the queue; further offers are ignored
        bus.push_valid = 1'b1;
        for (int i = 0; i < 12 && level != 4'd8; i++) begin
            bus.push_startaddr = 32'h4000 + 32'(i) * 32'h100;
            bus.push_stopaddr  = 32'h4080 + 32'(i) * 32'h100;
            step();
        end
        chk("t3_full_level", level, 8);
        chk("t3_full_rdy", bus.push_rdy, 0);
        step();
        chk("t3_overflow_ignored", level, 8);

        // flush with a simultaneous push while playing
        snap = drained_seen;
        bus.push_startaddr = 32'hdead0000;
        bus.push_stopaddr  = 32'hdead1000;
        flush = 1'b1;
        step();
        flush = 1'b0;
        bus.push_valid = 1'b0;
        chk("t4_level_cleared", level, 0);
        step();
        chk("t4_play_stop", bus.play_stop, 1);
        step();
        chk("t4_play_stop_one", bus.play_stop, 0);
        chk("t4_idle", busy, 0);
        n = starts_seen;
        run(4);
        chk("t4_no_relaunch", starts_seen - n, 0);
        chk("t4_no_drained", drained_seen - snap, 0);

        // rejected descriptors
        push(32'h3000, 32'h3000);
        chk("t3_bad_equal", irq_bad, 1);
        chk("t3_bad_level", level, 0);
        step();
        chk("t3_bad_one_cycle", irq_bad, 0);
        push(32'h7000, 32'h7100);
        push(32'h7200, 32'h7300);
        push(32'h5000, 32'h4000);
        chk("t3_bad_reversed", irq_bad, 1);
        chk("t3_bad_level_kept", level, 1);

        // reset during playback
        wait_start(n);
        step();
        snap = stops_seen;
        rst = 1'b1;
        step();
        chk("t5_level", level, 0);
        chk("t5_busy", busy, 0);
        chk("t5_start", bus.play_start, 0);
        chk("t5_stop", bus.play_stop, 0);
        chk("t5_startaddr", bus.play_startaddr, 0);
        chk("t5_stopaddr", bus.play_stopaddr, 0);
        rst = 1'b0;
        run(4);
        chk("t5_no_stop_pulse", stops_seen - snap, 0);

`ifdef PWM_QUEUE_LOOP_EN
        loop = 1'b1;
        push(32'h100, 32'h200);
        wait_start(n);
        chk("t6_first_addr", bus.play_startaddr, 32'h100);
        snap = drained_seen;
        for (int i = 0; i < 3; i++) begin
            run(2);
            bus.play_done = 1'b1;
            #1;
            chk("t6_rdy_blocked", bus.push_rdy, 0);
            step();
            bus.play_done = 1'b0;
            wait_start(n);
            chk("t6_relaunch_edges", n, 6);
            chk("t6_relaunch_addr", bus.play_startaddr, 32'h100);
        end
        chk("t6_no_drained", drained_seen - snap, 0);
        loop = 1'b0;
        run(2);
        pulse_done();
        run(10);
        chk("t6_drained_after_unloop", drained_seen - snap, 1);
`endif

        run(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end
endmodule
